pipe_reg_file: RTL and testbench

- Parametrised Y86-64 register file for the pipelined core; successor to the single-port decode/writeback register block.
- Two combinational read ports (decode stage) and two write ports (E and M, writeback stage) with write-first bypass.
- Per-register pending-write scoreboard that raises a data-hazard stall for decode.
- Sticky error flag for illegal indices and scoreboard overflow.

---
 rtl/pipe_reg_file.sv | 118 +++++++++++
 tb/tb_pipe_reg_file.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_file.sv
// Y86-64 register file: 2 comb read ports with write-first bypass, 2 write ports, pending-write scoreboard.
// Latency: reads/hazards zero-cycle, writes visible after one edge; backpressure: stall to decode, stalled issues not counted.
module pipe_reg_file #(
  parameter int                 DATA_W   = 64,
  parameter int                 NUM_REGS = 15,
  parameter logic [DATA_W-1:0]  SP_RESET = '0,
  parameter int                 PEND_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        src_a,
  input  logic [3:0]        src_b,
  input  logic              wb_en,
  input  logic [3:0]        dst_e,
  input  logic [DATA_W-1:0] val_e,
  input  logic [3:0]        dst_m,
  input  logic [DATA_W-1:0] val_m,
  input  logic              issue_valid,
  input  logic [3:0]        issue_dst_e,
  input  logic [3:0]        issue_dst_m,
  output logic [DATA_W-1:0] val_a,
  output logic [DATA_W-1:0] val_b,
  output logic              busy_a,
  output logic              busy_b,
  output logic              stall,
  output logic              reg_error
);

  localparam logic [3:0] RNONE = 4'hF;
  localparam int         PMAX  = (1 << PEND_W) - 1;
  localparam int         SW    = PEND_W + 2;

  logic [DATA_W-1:0] regs     [NUM_REGS];
  logic [PEND_W-1:0] pend     [NUM_REGS];
  logic [1:0]        dec_cnt  [NUM_REGS];
  logic [1:0]        inc_cnt  [NUM_REGS];
  logic [SW-1:0]     sum_w    [NUM_REGS];
  logic [PEND_W-1:0] pend_nxt [NUM_REGS];
  logic [NUM_REGS-1:0] ovf, udf;
  logic              issue_go;
  logic              idx_err;
  logic              err_now;

  // RNONE is never legal because NUM_REGS is at most 15.
  function automatic logic legal(input logic [3:0] idx);
    return int'(idx) < NUM_REGS;
  endfunction

  function automatic logic bad_idx(input logic [3:0] idx);
    return (idx != RNONE) && !legal(idx);
  endfunction

  function automatic logic [DATA_W-1:0] read_port(input logic [3:0] src);
    logic [DATA_W-1:0] v;
    v = '0;
    if (legal(src)) begin
      if (wb_en && src == dst_m)      v = val_m;
      else if (wb_en && src == dst_e) v = val_e;
      else begin
        for (int r = 0; r < NUM_REGS; r++)
          if (src == 4'(r)) v = regs[r];
      end
    end
    return v;
  endfunction

  // A register whose last pending writer retires this cycle is not busy.
  function automatic logic busy_port(input logic [3:0] src);
    logic b;
    b = 1'b0;
    for (int r = 0; r < NUM_REGS; r++)
      if (src == 4'(r)) b = {2'b00, pend[r]} > SW'(dec_cnt[r]);
    return b;
  endfunction

  assign val_a    = read_port(src_a);
  assign val_b    = read_port(src_b);
  assign busy_a   = busy_port(src_a);
  assign busy_b   = busy_port(src_b);
  assign stall    = issue_valid && (busy_a || busy_b);
  assign issue_go = issue_valid && !stall;

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      dec_cnt[r]  = 2'(wb_en && dst_e == 4'(r)) + 2'(wb_en && dst_m == 4'(r));
      inc_cnt[r]  = 2'(issue_go && issue_dst_e == 4'(r)) + 2'(issue_go && issue_dst_m == 4'(r));
      sum_w[r]    = {2'b00, pend[r]} + SW'(inc_cnt[r]);
      udf[r]      = sum_w[r] < SW'(dec_cnt[r]);
      ovf[r]      = !udf[r] && ((sum_w[r] - SW'(dec_cnt[r])) > SW'(PMAX));
      if (udf[r])      pend_nxt[r] = '0;
      else if (ovf[r]) pend_nxt[r] = PEND_W'(PMAX);
      else             pend_nxt[r] = PEND_W'(sum_w[r] - SW'(dec_cnt[r]));
    end
  end

  assign idx_err = bad_idx(src_a) || bad_idx(src_b)
                || (wb_en && (bad_idx(dst_e) || bad_idx(dst_m)))
                || (issue_valid && (bad_idx(issue_dst_e) || bad_idx(issue_dst_m)));
  assign err_now = idx_err || (|ovf) || (|udf);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs[r] <= (r == 4) ? SP_RESET : '0;
        pend[r] <= '0;
      end
      reg_error <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (wb_en && dst_m == 4'(r))      regs[r] <= val_m;
        else if (wb_en && dst_e == 4'(r)) regs[r] <= val_e;
        pend[r] <= pend_nxt[r];
      end
      if (err_now) reg_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_reg_file.sv
// Bench for pipe_reg_file: two configurations driven by the same stimulus, checked against a behavioural model.
module tb_pipe_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  src_a, src_b, dst_e, dst_m, issue_dst_e, issue_dst_m;
  logic        wb_en, issue_valid;
  logic [63:0] val_e, val_m;
  logic [63:0] va [2];
  logic [63:0] vb [2];
  logic        ba [2];
  logic        bb [2];
  logic        st [2];
  logic        er [2];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_reg_file #(.DATA_W(64), .NUM_REGS(15), .SP_RESET(64'h100), .PEND_W(2)) u_full (
    .clk(clk), .rst(rst), .src_a(src_a), .src_b(src_b), .wb_en(wb_en),
    .dst_e(dst_e), .val_e(val_e), .dst_m(dst_m), .val_m(val_m),
    .issue_valid(issue_valid), .issue_dst_e(issue_dst_e), .issue_dst_m(issue_dst_m),
    .val_a(va[0]), .val_b(vb[0]), .busy_a(ba[0]), .busy_b(bb[0]), .stall(st[0]), .reg_error(er[0]));

  pipe_reg_file #(.DATA_W(64), .NUM_REGS(8), .SP_RESET(64'h100), .PEND_W(1)) u_small (
    .clk(clk), .rst(rst), .src_a(src_a), .src_b(src_b), .wb_en(wb_en),
    .dst_e(dst_e), .val_e(val_e), .dst_m(dst_m), .val_m(val_m),
    .issue_valid(issue_valid), .issue_dst_e(issue_dst_e), .issue_dst_m(issue_dst_m),
    .val_a(va[1]), .val_b(vb[1]), .busy_a(ba[1]), .busy_b(bb[1]), .stall(st[1]), .reg_error(er[1]));

  // Reference model: architectural registers, pending-writer counts as plain ints.
  int          nr [2] = '{15, 8};
  int          pm [2] = '{3, 1};
  logic [63:0] m_reg  [2][16];
  int          m_pend [2][16];
  bit          m_err  [2];

  function automatic logic [63:0] m_read(int k, logic [3:0] s);
    if (int'(s) >= nr[k]) return 64'h0;
    if (wb_en && s == dst_m) return val_m;
    if (wb_en && s == dst_e) return val_e;
    return m_reg[k][s];
  endfunction

  function automatic int m_dec(int r);
    int d = 0;
    if (wb_en && int'(dst_e) == r) d++;
    if (wb_en && int'(dst_m) == r) d++;
    return d;
  endfunction

  function automatic bit m_busy(int k, logic [3:0] s);
    if (int'(s) >= nr[k]) return 1'b0;
    return m_pend[k][s] > m_dec(int'(s));
  endfunction

  function automatic bit m_stall(int k);
    return issue_valid && (m_busy(k, src_a) || m_busy(k, src_b));
  endfunction

  function automatic bit m_bad(int k, logic [3:0] idx);
    return idx != 4'hF && int'(idx) >= nr[k];
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      bit go;
      go = issue_valid && !m_stall(k);
      if (rst) begin
        for (int r = 0; r < 16; r++) begin
          m_reg[k][r]  = (r == 4) ? 64'h100 : 64'h0;
          m_pend[k][r] = 0;
        end
        m_err[k] = 1'b0;
      end else begin
        if (m_bad(k, src_a) || m_bad(k, src_b)) m_err[k] = 1'b1;
        if (wb_en && (m_bad(k, dst_e) || m_bad(k, dst_m))) m_err[k] = 1'b1;
        if (issue_valid && (m_bad(k, issue_dst_e) || m_bad(k, issue_dst_m))) m_err[k] = 1'b1;
        for (int r = 0; r < nr[k]; r++) begin
          int n;
          n = m_pend[k][r] - m_dec(r);
          if (go && int'(issue_dst_e) == r) n++;
          if (go && int'(issue_dst_m) == r) n++;
          if (n > pm[k]) begin n = pm[k]; m_err[k] = 1'b1; end
          if (n < 0)     begin n = 0;     m_err[k] = 1'b1; end
          m_pend[k][r] = n;
        end
        if (wb_en && int'(dst_e) < nr[k]) m_reg[k][dst_e] = val_e;
        if (wb_en && int'(dst_m) < nr[k]) m_reg[k][dst_m] = val_m;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic eval(input string tag);
    #4;
    for (int k = 0; k < 2; k++) begin
      string p;
      p = $sformatf("%s[%0d]", tag, k);
      chk({p, ".val_a"},     va[k],        m_read(k, src_a));
      chk({p, ".val_b"},     vb[k],        m_read(k, src_b));
      chk({p, ".busy_a"},    64'(ba[k]),   64'(m_busy(k, src_a)));
      chk({p, ".busy_b"},    64'(bb[k]),   64'(m_busy(k, src_b)));
      chk({p, ".stall"},     64'(st[k]),   64'(m_stall(k)));
      chk({p, ".reg_error"}, 64'(er[k]),   64'(m_err[k]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; src_a = 4'hF; src_b = 4'hF; wb_en = 1'b0;
    dst_e = 4'hF; dst_m = 4'hF; val_e = '0; val_m = '0;
    issue_valid = 1'b0; issue_dst_e = 4'hF; issue_dst_m = 4'hF;
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1; step(); rst = 1'b0;
  endtask

  initial begin
    idle();
    do_reset();

    // Reset values
    src_a = 4'd4; src_b = 4'd7;
    eval("reset");
    chk("reset.sp", va[0], 64'h100);
    chk("reset.r7", vb[0], 64'h0);
    chk("reset.err", 64'(er[0]), 64'h0);
    chk("reset.busy", 64'({ba[0], bb[0]}), 64'h0);
    step();

    // Write with same-cycle bypass, then registered read
    idle(); wb_en = 1'b1; dst_e = 4'd3; val_e = 64'h55; src_b = 4'd3;
    eval("write");
    chk("write.bypass", vb[0], 64'h55);
    step();
    idle(); src_a = 4'd3;
    eval("read");
    chk("read.r3", va[0], 64'h55);
    chk("read.underflow_err", 64'(er[0]), 64'h1);
    step();

    // Dual-port collision: M wins
    do_reset();
    wb_en = 1'b1; dst_e = 4'd2; dst_m = 4'd2; val_e = 64'hAA; val_m = 64'hBB; src_a = 4'd2;
    eval("collide");
    chk("collide.bypass", va[0], 64'hBB);
    step();
    idle(); src_a = 4'd2;
    eval("collide_after");
    chk("collide.reg", va[0], 64'hBB);
    step();

    // Scoreboard hazard and retirement
    do_reset();
    issue_valid = 1'b1; issue_dst_e = 4'd6;
    eval("issue6");
    step();
    issue_dst_e = 4'hF; src_a = 4'd6;
    eval("hazard");
    chk("hazard.busy", 64'(ba[0]), 64'h1);
    chk("hazard.stall", 64'(st[0]), 64'h1);
    step();
    wb_en = 1'b1; dst_e = 4'd6; val_e = 64'h66;
    eval("retire");
    chk("retire.busy", 64'(ba[0]), 64'h0);
    chk("retire.stall", 64'(st[0]), 64'h0);
    chk("retire.val", va[0], 64'h66);
    step();
    idle(); src_a = 4'd6;
    eval("retired");
    chk("retired.busy", 64'(ba[0]), 64'h0);
    chk("retired.err", 64'(er[0]), 64'h0);
    step();

    // Out-of-range read on the 8-register instance
    idle(); src_a = 4'd10;
    eval("oor");
    chk("oor.val", va[1], 64'h0);
    step();
    idle();
    eval("oor_after");
    chk("oor.err_small", 64'(er[1]), 64'h1);
    chk("oor.err_full", 64'(er[0]), 64'h0);
    step();
    eval("oor_sticky");
    chk("oor.sticky", 64'(er[1]), 64'h1);
    step();

    // Scoreboard overflow with one-bit counters
    do_reset();
    issue_valid = 1'b1; issue_dst_e = 4'd1;
    eval("ovf1"); step();
    eval("ovf2"); step();
    idle();
    eval("ovf_after");
    chk("ovf.err_small", 64'(er[1]), 64'h1);
    chk("ovf.err_full", 64'(er[0]), 64'h0);
    step();

    // Underflow: writeback with nothing pending
    do_reset();
    wb_en = 1'b1; dst_e = 4'd5; val_e = 64'h5;
    eval("udf"); step();
    idle();
    eval("udf_after");
    chk("udf.err", 64'(er[0]), 64'h1);
    step();

    // Reset mid-flight discards pending counts and same-cycle writebacks
    do_reset();
    issue_valid = 1'b1; issue_dst_e = 4'd3; issue_dst_m = 4'd3;
    eval("pend2"); step();
    idle(); rst = 1'b1; wb_en = 1'b1; dst_e = 4'd3; val_e = 64'h9;
    eval("midrst"); step();
    idle(); src_a = 4'd3; issue_valid = 1'b1;
    eval("midrst_after");
    chk("midrst.val", va[0], 64'h0);
    chk("midrst.busy", 64'(ba[0]), 64'h0);
    chk("midrst.stall", 64'(st[0]), 64'h0);
    chk("midrst.err", 64'(er[0]), 64'h0);
    step();

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      rst         = (i % 200) == 0;
      src_a       = 4'($urandom_range(0, 15));
      src_b       = 4'($urandom_range(0, 15));
      wb_en       = ($urandom_range(0, 2) == 0);
      dst_e       = 4'($urandom_range(0, 15));
      dst_m       = ($urandom_range(0, 3) == 0) ? dst_e : 4'($urandom_range(0, 15));
      val_e       = {$urandom, $urandom};
      val_m       = {$urandom, $urandom};
      issue_valid = ($urandom_range(0, 1) == 0);
      issue_dst_e = 4'($urandom_range(0, 15));
      issue_dst_m = 4'($urandom_range(0, 15));
      eval("rnd");
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
